// File: rtl/tmr_weight_store.sv
// Triple-modular-redundant weight store.
// Weights arrive over an LW-bit valid/ready stream and are shifted into three
// identical copies. The layers see the bitwise majority of the copies while a
// background scrubber walks the store one SCRUB_W-bit word per cycle, rewrites
// any word whose copies disagree with its majority, and counts the repairs.
// A fault-injection port flips a single bit of one copy for verification.
module tmr_weight_store #(
  parameter int WEIGHTS_B = 12864,
  parameter int LW        = 1,
  parameter int SCRUB_W   = 64,
  parameter int ERR_CNT_B = 16,
  parameter bit SCRUB_EN  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic                         k_valid,
  input  logic [LW-1:0]                k,
  output logic                         k_ready,
  output logic                         loaded,
  output logic [WEIGHTS_B-1:0]         weights_q,
  output logic                         err_pulse,
  output logic [ERR_CNT_B-1:0]         err_cnt,
  input  logic                         err_clr,
  input  logic                         inj_en,
  input  logic [1:0]                   inj_sel,
  input  logic [$clog2(WEIGHTS_B)-1:0] inj_idx
);

  localparam int NBEATS = WEIGHTS_B / LW;
  localparam int NWORDS = WEIGHTS_B / SCRUB_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int SP_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(NBEATS - 1);
  localparam logic [SP_W-1:0]      LAST_WORD = SP_W'(NWORDS - 1);
  localparam logic [ERR_CNT_B-1:0] ERR_MAX   = '1;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SP_W-1:0]      sp_q, sp_d;
  logic                 loaded_q, loaded_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [ERR_CNT_B-1:0] err_cnt_q, err_cnt_d;
  logic [WEIGHTS_B-1:0] copy_q [3];
  logic [WEIGHTS_B-1:0] copy_d [3];

  logic                 accept;
  logic                 scrub_act;
  logic                 scrub_hit;
  logic [SCRUB_W-1:0]   w0, w1, w2, w_maj;
  logic [WEIGHTS_B-1:0] inj_mask;

  // Handshake: only LOAD takes beats, and a start in the same cycle wins.
  assign k_ready = (state_q == ST_LOAD);
  assign accept  = k_ready & k_valid & ~start;

  // Layers always see the voted value of the registered copies.
  assign weights_q = (copy_q[0] & copy_q[1]) | (copy_q[0] & copy_q[2]) |
                     (copy_q[1] & copy_q[2]);

  assign loaded    = loaded_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

  // Scrub word at SP: extract all three copies and vote them.
  always_comb begin
    w0        = copy_q[0][int'(sp_q) * SCRUB_W +: SCRUB_W];
    w1        = copy_q[1][int'(sp_q) * SCRUB_W +: SCRUB_W];
    w2        = copy_q[2][int'(sp_q) * SCRUB_W +: SCRUB_W];
    w_maj     = (w0 & w1) | (w0 & w2) | (w1 & w2);
    scrub_act = SCRUB_EN && (state_q == ST_READY);
    scrub_hit = scrub_act && ((w0 != w1) || (w0 != w2));
  end

  // An index past the top of the store shifts the mask out to zero, so it is
  // silently ignored rather than aliasing onto a valid bit.
  assign inj_mask = WEIGHTS_B'(1) << inj_idx;

  // Copy next-state: shift on an accepted beat, rewrite on a scrub hit, then
  // apply the injection last so it overrides either update on its bit.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      copy_d[i] = copy_q[i];
      if (accept) begin
        copy_d[i] = {k, copy_q[i][WEIGHTS_B-1:LW]};
      end else if (scrub_hit) begin
        copy_d[i][int'(sp_q) * SCRUB_W +: SCRUB_W] = w_maj;
      end
      if (inj_en && (inj_sel == 2'(i))) begin
        copy_d[i] = copy_d[i] ^ inj_mask;
      end
    end
  end

  // Control next-state: load FSM, beat counter, scrub pointer, error counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sp_d        = sp_q;
    loaded_d    = loaded_q;
    err_pulse_d = scrub_hit;
    err_cnt_d   = err_cnt_q;

    if (start) begin
      state_d  = ST_LOAD;
      cnt_d    = '0;
      sp_d     = '0;
      loaded_d = 1'b0;
    end else if (accept) begin
      if (cnt_q == LAST_BEAT) begin
        state_d  = ST_READY;
        cnt_d    = '0;
        loaded_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (scrub_act) begin
      sp_d = (sp_q == LAST_WORD) ? '0 : sp_q + 1'b1;
    end

    if (err_clr) begin
      err_cnt_d = '0;
    end else if (scrub_hit && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (!rstn) begin
      state_q     <= ST_EMPTY;
      cnt_q       <= '0;
      sp_q        <= '0;
      loaded_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sp_q        <= sp_d;
      loaded_q    <= loaded_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Weight copies.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: the copies are reset even though they are wide storage, because
    // the voted output must read zero straight out of reset.
    if (!rstn) begin
      for (int i = 0; i < 3; i++) begin
        copy_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        copy_q[i] <= copy_d[i];
      end
    end
  end

endmodule

// File: doc/tmr_weight_store.md
# tmr_weight_store

Parametrised triple-modular-redundant weight store that supersedes the single serial-shift TMR weight register feeding the quantised model datapath (qconv2d / qdense / qact). It accepts weights over an LW-bit valid/ready stream and holds three copies. It presents the bitwise majority to the layers and continuously scrubs the copies, repairing upsets and counting them. A fault-injection port lets verification flip individual bits.

## Interface
- WEIGHTS_B, 12864: total weight bits; must be a multiple of LW and of SCRUB_W.
- LW, 1: load lane width in bits per accepted beat.
- SCRUB_W, 64: bits checked and repaired per scrub cycle.
- ERR_CNT_B, 16: width of the saturating error counter.
- SCRUB_EN, 1: 0 disables the scrubber; voting still applies.

- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  pulse: begin a new load, discarding the current contents
- k_valid  in  1  load beat valid
- k  in  LW  load beat data
- k_ready  out  1  beat accepted when k_valid & k_ready
- loaded  out  1  all WEIGHTS_B bits received since the last start
- weights_q  out  WEIGHTS_B  bitwise majority of the three copies
- err_pulse  out  1  one-cycle pulse per repaired scrub word
- err_cnt  out  ERR_CNT_B  saturating count of repaired words
- err_clr  in  1  clear err_cnt
- inj_en  in  1  fault-injection strobe
- inj_sel  in  2  copy to flip (0..2; 3 is ignored)
- inj_idx  in  clog2(WEIGHTS_B)  bit index to flip

## Operation
- Reset: all copies 0, state EMPTY, beat counter 0, scrub pointer 0. k_ready=0, loaded=0, err_pulse=0, err_cnt=0, weights_q=0.
- States:
  - EMPTY: start → LOAD.
  - LOAD: start → LOAD with beat counter cleared; last beat accepted → READY.
  - READY: start → LOAD.
- k_ready=1 only in LOAD. k_valid outside LOAD is ignored.
- Accepted beat: every copy is updated as copy = {k, copy[WEIGHTS_B-1:LW]}. The first beat ends at bits [LW-1:0] after WEIGHTS_B/LW beats.
- start clears loaded at the next edge. Copies are not cleared; they are shifted over.
- Scrub runs only in READY with SCRUB_EN=1.
  - Each cycle it examines word SP (bits SP*SCRUB_W +: SCRUB_W) of all three copies.
  - If the copies differ anywhere in the word, all three copies of the word are written with the majority, err_pulse=1 next cycle, and err_cnt increments.
  - SP wraps from WEIGHTS_B/SCRUB_W-1 to 0. SP resets to 0 on entry to LOAD.
- err_cnt saturates at 2^ERR_CNT_B-1. err_clr has priority over a same-cycle increment, giving 0.
- Injection: when inj_en=1 and inj_sel<3, bit inj_idx of the selected copy is XORed at the edge.
  - The XOR is applied after any same-cycle shift or scrub write, so injection wins on that bit.
  - Injection is legal in any state except reset.
- weights_q is purely combinational majority of the registered copies. No other output depends combinationally on inputs.

## Timing
- Load latency: loaded rises on the edge that accepts the final beat, i.e. visible in the cycle after the handshake.
- weights_q reflects a shift, repair or injection in the cycle after the edge that performs it.
- Detection of a word at SP in cycle t produces:
  - repair at the edge ending t;
  - err_pulse high during t+1;
  - err_cnt updated in t+1.
- Worst-case time from a single upset to repair: WEIGHTS_B/SCRUB_W cycles.
- start and an accepted beat in the same cycle: start wins; the beat is not accepted (k_ready drops the next cycle only if state leaves LOAD, otherwise the counter restarts at 0).
- rstn assertion mid-load or mid-scrub clears everything asynchronously. No partial repair or count update survives.

## Test plan
- WEIGHTS_B=12, LW=4, SCRUB_W=4 for all cases.
- Reset; start; beats 0xA, 0xB, 0xC → loaded=1 after the third handshake; weights_q=0xCBA; err_cnt=0.
- Loaded 0xCBA; inject copy 1, bit 5 → weights_q stays 0xCBA; within 3 cycles exactly one err_pulse; err_cnt=1; all copies equal 0xCBA.
- Loaded 0xCBA; inject bit 5 in copies 0 and 1 in consecutive cycles before scrub reaches word 1 → weights_q=0xC9A; the scrubber aligns copy 2; err_cnt=1.
- start, beat 0x1, start again, beats 0x4, 0x5, 0x6 → loaded stays 0 until the third post-restart beat; weights_q=0x654.
- ERR_CNT_B=2; five separate single-copy injections → err_cnt saturates at 3. Then err_clr in the same cycle as a detection → err_cnt=0.
- Assert rstn low while scrubbing a pending error → weights_q=0, loaded=0, err_cnt=0, k_ready=0 immediately; no err_pulse after release.
